satatrn_rxdemux: RTL and testbench
==================================

# satatrn_rxdemux

Receive-side FIS demultiplexer for the SATA transport layer, the counterpart to the transmit arbiter. It takes the FIS word stream arriving from the link layer in the PHY clock domain and steers it to one of two outputs. DATA FISes (type 8'h46) have their header word stripped and their payload sent to the data port. All other FISes are passed whole, header included, to the register port, truncated to a maximum length. Single clock domain; any crossing to the bus clock happens downstream.

## Interface
- `MAXREG`, default 7: maximum register-FIS length in words; 2 ≤ MAXREG ≤ 15.
- `OPT_LOWPOWER`, default 1'b0: when set, data/last outputs are forced to zero whenever their valid is low.
- `i_phy_clk`  in  1  clock.
- `i_phy_reset_n`  in  1  reset; asynchronous, active-low.
- `i_valid`  in  1  incoming FIS word valid (from the link layer).
- `o_ready`  out  1  incoming word accepted when `i_valid && o_ready`.
- `i_data`  in  32  incoming word; on the first word of a FIS, `[31:24]` is the FIS type.
- `i_last`  in  1  marks the final word of a FIS.
- `o_data_valid`, `i_data_ready`, `o_data_data[31:0]`, `o_data_last`: DATA FIS payload stream (out, in, out, out).
- `o_reg_valid`, `i_reg_ready`, `o_reg_data[31:0]`, `o_reg_last`: non-DATA FIS stream (out, in, out, out).
- `o_rx_datafis`  out  1  one-cycle pulse when a DATA FIS header is accepted.
- `o_err_empty`  out  1  one-cycle pulse when a DATA FIS header arrives with `i_last=1`.
- `o_reg_overflow`  out  1  one-cycle pulse when a register FIS exceeds `MAXREG` words.

## Operation
- States: IDLE (expecting a header), DATA, REG, DROP. Reset and any `i_last` acceptance return to IDLE. In DROP, the return to IDLE happens when the `i_last` word is consumed.
- IDLE, header accepted:
  - Type 8'h46 with `!i_last`: consume the word with no output, pulse `o_rx_datafis`, go to DATA.
  - Type 8'h46 with `i_last`: consume, pulse `o_rx_datafis` and `o_err_empty`, stay in IDLE.
  - Any other type: forward the word to the reg port, set the word count to 1, go to REG. If `i_last`, set `o_reg_last=1` and stay in IDLE.
- DATA: each accepted word goes to the data port with `o_data_last = i_last`.
- REG: each accepted word goes to the reg port and increments the count.
  - When the count reaches `MAXREG` on a word without `i_last`: force `o_reg_last=1`, pulse `o_reg_overflow`, go to DROP.
- DROP: `o_ready=1`; words are discarded until the `i_last` word is consumed.
- `o_ready`:
  - IDLE: `!o_reg_valid || i_reg_ready`, regardless of type.
  - DATA: `!o_data_valid || i_data_ready`.
  - REG: same as IDLE.
  - DROP: 1.
- Each output is a single register stage. Hold rule: if valid is high and ready is low, data and last stay stable. Valid is cleared on a ready handshake when no new word is loaded.
- The word count is 4 bits wide and never wraps; it saturates at MAXREG by leaving REG.

## Timing
- Reset values:
  - state IDLE, count 0.
  - `o_data_valid`, `o_reg_valid`, `o_rx_datafis`, `o_err_empty`, `o_reg_overflow` all 0.
  - data and last outputs 0.
- Latency: a word accepted at cycle N appears on its output valid at N+1.
- Throughput: one word per cycle per port when the downstream ready is held high.
- Pulses are registered, asserted at N+1 for a header or overflow word accepted at N, and last exactly one cycle.
- Back-to-back FISes: a header accepted in the cycle after a `last` word is routed correctly, with no bubble required.
- Reset mid-FIS: outputs drop asynchronously. The partial FIS is lost, and the next word received is treated as a header.
- A stalled port never blocks the other port's queued word. Input is not accepted while the target port is stalled.

## Test plan
- D2H Register FIS, header 32'h34xx_xxxx plus 4 words, ready held high -> 5 words on the reg port with last on word 5; data port idle; `o_ready` high throughout.
- DATA FIS, header 32'h4600_0000 plus 3 payload words 1, 2, 3 -> data port emits 1, 2, 3 with last on 3; one `o_rx_datafis` pulse; no reg output.
- DATA header with `i_last=1` -> no outputs; `o_rx_datafis` and `o_err_empty` both pulse once; the following FIS is routed normally.
- 10-word non-DATA FIS with MAXREG=7 -> 7 reg words with last on word 7; one `o_reg_overflow` pulse; words 8-10 consumed and discarded.
- Random `i_data_ready`/`i_reg_ready` backpressure over 100 mixed FISes -> output streams match the reference model exactly; data is held stable while stalled; no word is lost or duplicated.
- Assert `i_phy_reset_n` low during DATA word 2 of 5, then release and send a register FIS -> valids drop immediately; the register FIS is delivered intact to the reg port.

Source files
------------

// File: rtl/satatrn_rxdemux_if.sv
// satatrn_rxdemux_if: link-layer input stream plus data/register output streams and status pulses
interface satatrn_rxdemux_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        i_last;
  logic        o_data_valid;
  logic        i_data_ready;
  logic [31:0] o_data_data;
  logic        o_data_last;
  logic        o_reg_valid;
  logic        i_reg_ready;
  logic [31:0] o_reg_data;
  logic        o_reg_last;
  logic        o_rx_datafis;
  logic        o_err_empty;
  logic        o_reg_overflow;
  modport slave (
    input  i_valid, i_data, i_last, i_data_ready, i_reg_ready,
    output o_ready, o_data_valid, o_data_data, o_data_last,
           o_reg_valid, o_reg_data, o_reg_last,
           o_rx_datafis, o_err_empty, o_reg_overflow
  );
  modport master (
    output i_valid, i_data, i_last, i_data_ready, i_reg_ready,
    input  o_ready, o_data_valid, o_data_data, o_data_last,
           o_reg_valid, o_reg_data, o_reg_last,
           o_rx_datafis, o_err_empty, o_reg_overflow
  );
endinterface

// File: rtl/satatrn_rxdemux.sv
// satatrn_rxdemux: steers received FIS words to a DATA payload port or a truncated register-FIS port
module satatrn_rxdemux #(
  parameter int MAXREG       = 7,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input logic              i_phy_clk,
  input logic              i_phy_reset_n,
  satatrn_rxdemux_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, REG, DROP} state_t;
  localparam logic [3:0] CLAST = 4'(MAXREG - 1);
  state_t state, state_nx;
  logic [3:0] count;
  logic accept, is_dhdr, at_max, load_d, load_r, ovf_nx, dfis_nx;
  // state register
  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n)
    if (!i_phy_reset_n) state <= IDLE;
    else state <= state_nx;
  // next-state: every accepted last word returns to IDLE; the MAXREG-th word without last diverts to DROP
  always_comb begin
    state_nx = state;
    if (accept)
      case (state)
        IDLE:    state_nx = bus.i_last ? IDLE : is_dhdr ? DATA : REG;
        DATA:    state_nx = bus.i_last ? IDLE : DATA;
        REG:     state_nx = bus.i_last ? IDLE : at_max ? DROP : REG;
        default: state_nx = bus.i_last ? IDLE : DROP;
      endcase
  end
  // handshake and routing decodes; IDLE/REG follow the reg port even for a DATA header
  always_comb begin
    bus.o_ready = state == DROP ? 1'b1 :
                  state == DATA ? (!bus.o_data_valid || bus.i_data_ready) :
                                  (!bus.o_reg_valid || bus.i_reg_ready);
    accept  = bus.i_valid && bus.o_ready;
    is_dhdr = bus.i_data[31:24] == 8'h46;
    at_max  = count == CLAST;
    load_d  = accept && state == DATA;
    load_r  = accept && ((state == IDLE && !is_dhdr) || state == REG);
    ovf_nx  = accept && state == REG && !bus.i_last && at_max;
    dfis_nx = accept && state == IDLE && is_dhdr;
  end
  // register-FIS word count; the header counts as word 1 and REG is left before it can exceed MAXREG
  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n)
    if (!i_phy_reset_n) count <= '0;
    else if (load_r) count <= state == IDLE ? 4'd1 : count + 4'd1;
  // data port output stage
  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n)
    if (!i_phy_reset_n) begin
      bus.o_data_valid <= 1'b0;
      bus.o_data_data  <= '0;
      bus.o_data_last  <= 1'b0;
    end else if (load_d) begin
      bus.o_data_valid <= 1'b1;
      bus.o_data_data  <= bus.i_data;
      bus.o_data_last  <= bus.i_last;
    end else if (bus.i_data_ready) begin
      bus.o_data_valid <= 1'b0;
      if (OPT_LOWPOWER) begin
        bus.o_data_data <= '0;
        bus.o_data_last <= 1'b0;
      end
    end
  // register port output stage; truncation forces last on the overflow word
  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n)
    if (!i_phy_reset_n) begin
      bus.o_reg_valid <= 1'b0;
      bus.o_reg_data  <= '0;
      bus.o_reg_last  <= 1'b0;
    end else if (load_r) begin
      bus.o_reg_valid <= 1'b1;
      bus.o_reg_data  <= bus.i_data;
      bus.o_reg_last  <= bus.i_last || ovf_nx;
    end else if (bus.i_reg_ready) begin
      bus.o_reg_valid <= 1'b0;
      if (OPT_LOWPOWER) begin
        bus.o_reg_data <= '0;
        bus.o_reg_last <= 1'b0;
      end
    end
  // one-cycle status pulses
  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n)
    if (!i_phy_reset_n) begin
      bus.o_rx_datafis   <= 1'b0;
      bus.o_err_empty    <= 1'b0;
      bus.o_reg_overflow <= 1'b0;
    end else begin
      bus.o_rx_datafis   <= dfis_nx;
      bus.o_err_empty    <= dfis_nx && bus.i_last;
      bus.o_reg_overflow <= ovf_nx;
    end
endmodule

// File: tb/tb_satatrn_rxdemux.sv
// tb_satatrn_rxdemux: directed and backpressured checks of the receive FIS demultiplexer
module tb_satatrn_rxdemux;
  localparam int MAXREG = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  satatrn_rxdemux_if bus();
  satatrn_rxdemux #(.MAXREG(MAXREG), .OPT_LOWPOWER(1'b0)) dut (
    .i_phy_clk(clk),
    .i_phy_reset_n(rst_n),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  logic [32:0] got_d[$], got_r[$], exp_d[$], exp_r[$];
  int n_dfis, n_err, n_ovf, e_dfis, e_err, e_ovf, hold_err, stalls;
  bit bp = 1'b0;
  logic want_dr = 1'b1, want_rr = 1'b1, rnd_dr = 1'b1, rnd_rr = 1'b1;
  assign bus.i_data_ready = bp ? rnd_dr : want_dr;
  assign bus.i_reg_ready  = bp ? rnd_rr : want_rr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    got_d.delete(); got_r.delete(); exp_d.delete(); exp_r.delete();
    n_dfis = 0; n_err = 0; n_ovf = 0; e_dfis = 0; e_err = 0; e_ovf = 0;
    hold_err = 0; stalls = 0;
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    int n = 0;
    logic r;
    bus.i_valid = 1'b1; bus.i_data = w; bus.i_last = l;
    do begin
      @(negedge clk);
      r = bus.o_ready;
      if (!r) stalls++;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 200);
    if (!r) check("send_timeout", r, 1);
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0;
  endtask

  function automatic logic [31:0] word(input logic [31:0] hdr, input int i);
    return i == 0 ? hdr : {8'h5A, hdr[15:0], 8'(i)};
  endfunction

  task automatic send_fis(input logic [31:0] hdr, input int n);
    int m;
    for (int i = 0; i < n; i++) send(word(hdr, i), i == n - 1);
    if (hdr[31:24] == 8'h46) begin
      e_dfis++;
      if (n == 1) e_err++;
      for (int i = 1; i < n; i++) exp_d.push_back({i == n - 1, word(hdr, i)});
    end else begin
      m = n < MAXREG ? n : MAXREG;
      for (int i = 0; i < m; i++) exp_r.push_back({i == m - 1, word(hdr, i)});
      if (n > MAXREG) e_ovf++;
    end
  endtask

  task automatic drain();
    logic done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = !bus.o_data_valid && !bus.o_reg_valid;
    end
    check("drain", done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : bp_drv
    forever begin
      @(posedge clk);
      #1;
      rnd_dr = 1'($urandom_range(0, 1));
      rnd_rr = 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitor
    logic pr_stall, pd_stall;
    logic [32:0] pr_w, pd_w;
    pr_stall = 1'b0; pd_stall = 1'b0; pr_w = '0; pd_w = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pr_stall = 1'b0; pd_stall = 1'b0;
      end else begin
        if (bus.o_reg_valid && bus.i_reg_ready) got_r.push_back({bus.o_reg_last, bus.o_reg_data});
        if (bus.o_data_valid && bus.i_data_ready) got_d.push_back({bus.o_data_last, bus.o_data_data});
        if (pr_stall && (!bus.o_reg_valid || {bus.o_reg_last, bus.o_reg_data} !== pr_w)) hold_err++;
        if (pd_stall && (!bus.o_data_valid || {bus.o_data_last, bus.o_data_data} !== pd_w)) hold_err++;
        pr_stall = bus.o_reg_valid && !bus.i_reg_ready;
        pd_stall = bus.o_data_valid && !bus.i_data_ready;
        pr_w = {bus.o_reg_last, bus.o_reg_data};
        pd_w = {bus.o_data_last, bus.o_data_data};
        if (bus.o_rx_datafis) n_dfis++;
        if (bus.o_err_empty) n_err++;
        if (bus.o_reg_overflow) n_ovf++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int len;
    logic [7:0] typ;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0;
    clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valids", {bus.o_data_valid, bus.o_reg_valid}, 0);
    check("rst_pulses", {bus.o_rx_datafis, bus.o_err_empty, bus.o_reg_overflow}, 0);
    check("rst_outs", {bus.o_data_data, bus.o_data_last, bus.o_reg_data, bus.o_reg_last}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", bus.o_ready, 1);

    clear();
    send(32'h3400_0001, 0); send(32'd11, 0); send(32'd22, 0); send(32'd33, 0); send(32'd44, 1);
    drain();
    check("d2h_len", got_r.size(), 5);
    check("d2h_w0", got_r[0], {1'b0, 32'h3400_0001});
    check("d2h_w3", got_r[3], {1'b0, 32'd33});
    check("d2h_w4", got_r[4], {1'b1, 32'd44});
    check("d2h_dlen", got_d.size(), 0);
    check("d2h_stalls", stalls, 0);

    clear();
    send(32'h4600_0000, 0);
    check("dfis_pulse", {bus.o_rx_datafis, bus.o_err_empty}, 2'b10);
    send(32'd1, 0);
    check("dfis_latency", {bus.o_data_valid, bus.o_data_data}, {1'b1, 32'd1});
    send(32'd2, 0); send(32'd3, 1);
    drain();
    check("dfis_len", got_d.size(), 3);
    check("dfis_w0", got_d[0], {1'b0, 32'd1});
    check("dfis_w1", got_d[1], {1'b0, 32'd2});
    check("dfis_w2", got_d[2], {1'b1, 32'd3});
    check("dfis_rlen", got_r.size(), 0);
    check("dfis_count", n_dfis, 1);

    clear();
    send(32'h4600_0000, 1);
    check("empty_pulse", {bus.o_rx_datafis, bus.o_err_empty}, 2'b11);
    send(32'h2700_00AA, 0); send(32'h0000_00BB, 1);
    drain();
    check("empty_dlen", got_d.size(), 0);
    check("empty_rlen", got_r.size(), 2);
    check("empty_r0", got_r[0], {1'b0, 32'h2700_00AA});
    check("empty_r1", got_r[1], {1'b1, 32'h0000_00BB});
    check("empty_counts", {8'(n_dfis), 8'(n_err)}, {8'd1, 8'd1});

    clear();
    for (int i = 0; i < 7; i++) send(i == 0 ? 32'h3400_0000 : i, i == 6);
    drain();
    check("max_len", got_r.size(), 7);
    check("max_last", got_r[6], {1'b1, 32'd6});
    check("max_ovf", n_ovf, 0);

    clear();
    for (int i = 0; i < 10; i++) send(i == 0 ? 32'h3900_0000 : i, i == 9);
    send(32'h3400_0000, 1);
    drain();
    check("ovf_len", got_r.size(), 8);
    check("ovf_w5", got_r[5], {1'b0, 32'd5});
    check("ovf_w6", got_r[6], {1'b1, 32'd6});
    check("ovf_next", got_r[7], {1'b1, 32'h3400_0000});
    check("ovf_pulse", n_ovf, 1);
    check("ovf_stalls", stalls, 0);

    clear();
    bp = 1'b1;
    for (int f = 0; f < 100; f++) begin
      case ($urandom_range(0, 4))
        0, 1: typ = 8'h46;
        2: typ = 8'h34;
        3: typ = 8'h39;
        default: typ = 8'hA1;
      endcase
      len = $urandom_range(1, 11);
      send_fis({typ, 8'(f), 16'($urandom)}, len);
    end
    bp = 1'b0;
    drain();
    check("rnd_dlen", got_d.size(), exp_d.size());
    check("rnd_rlen", got_r.size(), exp_r.size());
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) check("rnd_d", got_d[i], exp_d[i]);
    for (int i = 0; i < got_r.size() && i < exp_r.size(); i++) check("rnd_r", got_r[i], exp_r[i]);
    check("rnd_hold", hold_err, 0);
    check("rnd_dfis", n_dfis, e_dfis);
    check("rnd_err", n_err, e_err);
    check("rnd_ovf", n_ovf, e_ovf);

    clear();
    want_dr = 1'b0;
    send(32'h4600_0000, 0);
    send(32'd1, 0);
    bus.i_valid = 1'b1; bus.i_data = 32'd2; bus.i_last = 1'b0;
    #2;
    check("rst_pre", {bus.o_data_valid, bus.o_ready}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rst_async", {bus.o_data_valid, bus.o_reg_valid}, 0);
    bus.i_valid = 1'b0; bus.i_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    want_dr = 1'b1;
    @(posedge clk);
    #1;
    clear();
    send(32'h3400_0005, 0); send(32'd7, 0); send(32'd8, 1);
    drain();
    check("rst_rlen", got_r.size(), 3);
    check("rst_r0", got_r[0], {1'b0, 32'h3400_0005});
    check("rst_r2", got_r[2], {1'b1, 32'd8});
    check("rst_dlen", got_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
